// File: rtl/nmea_tx_sched.sv
// NMEA transmit scheduler: round-robin arbitration of N_SRC payload producers onto one
// UART byte channel, framing each payload as "$<payload>*HH\r\n".
module nmea_tx_sched #(
  parameter int N_SRC       = 4,
  parameter int MAX_PAYLOAD = 76
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_SRC-1:0]   i_req,
  input  logic [8*N_SRC-1:0] i_data,
  input  logic [N_SRC-1:0]   i_last,
  output logic [N_SRC-1:0]   o_ack,
  output logic [N_SRC-1:0]   o_grant,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_err_len
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_PAYLOAD, S_STAR, S_HI, S_LO, S_CR, S_LF, S_DRAIN
  } state_t;

  // Uppercase ASCII hex digit for one checksum nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = {4'h3, nib};
    end else begin
      res = 8'h37 + {4'h0, nib};
    end
    return res;
  endfunction

  state_t            state_r;
  logic [N_SRC-1:0]  grant_r;
  logic [IW-1:0]     gidx_r;
  logic [IW-1:0]     ptr_r;
  logic [7:0]        csum_r;
  logic [CW-1:0]     cnt_r;
  logic              trunc_r;
  logic [7:0]        tx_byte_r;
  logic              tx_valid_r;
  logic              err_len_r;

  logic              req_g_s;
  logic              last_g_s;
  logic [7:0]        data_g_s;
  logic              valid_s;
  logic [7:0]        tx_data_s;
  logic              xfer_s;
  logic              found_s;
  logic [IW-1:0]     pick_s;
  logic [IW-1:0]     idx_s;
  logic [N_SRC-1:0]  ack_s;

  // Round-robin search starting one past the last owner.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IW{1'b0}};
    idx_s   = ptr_r;
    for (int i = 0; i < N_SRC; i++) begin
      idx_s = (idx_s == IW'(N_SRC - 1)) ? {IW{1'b0}} : idx_s + 1'b1;
      if (!found_s && i_req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Owner's lane select and channel mux: payload bytes pass straight through,
  // framing bytes come from the holding register.
  always_comb begin
    req_g_s  = i_req[gidx_r];
    last_g_s = i_last[gidx_r];
    data_g_s = i_data[{gidx_r, 3'b000} +: 8];
    if (state_r == S_PAYLOAD) begin
      valid_s   = req_g_s;
      tx_data_s = data_g_s;
    end else begin
      valid_s   = tx_valid_r;
      tx_data_s = tx_byte_r;
    end
    xfer_s = valid_s & i_tx_ready;
  end

  // Consume acknowledge: on transfers in PAYLOAD, unconditionally in DRAIN.
  always_comb begin
    ack_s = {N_SRC{1'b0}};
    case (state_r)
      S_PAYLOAD: ack_s[gidx_r] = req_g_s & i_tx_ready;
      S_DRAIN:   ack_s[gidx_r] = req_g_s;
      default:   ack_s = {N_SRC{1'b0}};
    endcase
  end

  // Sentence sequencer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r    <= S_IDLE;
      grant_r    <= {N_SRC{1'b0}};
      gidx_r     <= {IW{1'b0}};
      ptr_r      <= IW'(N_SRC - 1);
      csum_r     <= 8'h00;
      cnt_r      <= {CW{1'b0}};
      trunc_r    <= 1'b0;
      tx_byte_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      err_len_r  <= 1'b0;
    end else begin
      err_len_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            grant_r    <= {{(N_SRC-1){1'b0}}, 1'b1} << pick_s;
            gidx_r     <= pick_s;
            ptr_r      <= pick_s;
            csum_r     <= 8'h00;
            cnt_r      <= {CW{1'b0}};
            tx_byte_r  <= 8'h24;
            tx_valid_r <= 1'b1;
            state_r    <= S_START;
          end
        end
        S_START: begin
          if (xfer_s) begin
            tx_valid_r <= 1'b0;
            state_r    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer_s) begin
            csum_r <= csum_r ^ data_g_s;
            cnt_r  <= cnt_r + 1'b1;
            // A genuine last byte wins over truncation at the length limit.
            if (last_g_s) begin
              tx_byte_r  <= 8'h2A;
              tx_valid_r <= 1'b1;
              state_r    <= S_STAR;
            end else if (cnt_r == CW'(MAX_PAYLOAD - 1)) begin
              tx_byte_r  <= 8'h2A;
              tx_valid_r <= 1'b1;
              err_len_r  <= 1'b1;
              trunc_r    <= 1'b1;
              state_r    <= S_STAR;
            end
          end
        end
        S_STAR: begin
          if (xfer_s) begin
            tx_byte_r <= hex_ascii(csum_r[7:4]);
            state_r   <= S_HI;
          end
        end
        S_HI: begin
          if (xfer_s) begin
            tx_byte_r <= hex_ascii(csum_r[3:0]);
            state_r   <= S_LO;
          end
        end
        S_LO: begin
          if (xfer_s) begin
            tx_byte_r <= 8'h0D;
            state_r   <= S_CR;
          end
        end
        S_CR: begin
          if (xfer_s) begin
            tx_byte_r <= 8'h0A;
            state_r   <= S_LF;
          end
        end
        S_LF: begin
          if (xfer_s) begin
            tx_valid_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            if (trunc_r) begin
              state_r <= S_DRAIN;
            end else begin
              grant_r <= {N_SRC{1'b0}};
              state_r <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (req_g_s && last_g_s) begin
            trunc_r <= 1'b0;
            grant_r <= {N_SRC{1'b0}};
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          grant_r    <= {N_SRC{1'b0}};
          tx_valid_r <= 1'b0;
          trunc_r    <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack      = ack_s;
  assign o_grant    = grant_r;
  assign o_tx_data  = tx_data_s;
  assign o_tx_valid = valid_s;
  assign o_busy     = (state_r != S_IDLE);
  assign o_err_len  = err_len_r;

endmodule

// File: tb/tb_nmea_tx_sched.sv
// Directed bench for nmea_tx_sched: string-driven source model, byte capture and
// hand-computed sentences; a MAX_PAYLOAD=4 instance covers truncation.
module tb_nmea_tx_sched;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     last;
  logic [8*N-1:0]   data;
  logic             ready;
  logic             use_t;

  logic [N-1:0] req_a, req_b, ack_a, ack_b, grant_a, grant_b;
  logic [7:0]   txd_a, txd_b;
  logic         txv_a, txv_b, busy_a, busy_b, err_a, err_b;

  logic [N-1:0] ack, grant;
  logic [7:0]   txd;
  logic         txv, busy, err;

  always #5 clk = ~clk;

  assign req_a = use_t ? 4'b0000 : req;
  assign req_b = use_t ? req : 4'b0000;
  assign ack   = use_t ? ack_b   : ack_a;
  assign grant = use_t ? grant_b : grant_a;
  assign txd   = use_t ? txd_b   : txd_a;
  assign txv   = use_t ? txv_b   : txv_a;
  assign busy  = use_t ? busy_b  : busy_a;
  assign err   = use_t ? err_b   : err_a;

  nmea_tx_sched #(.N_SRC(N), .MAX_PAYLOAD(76)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_data(data), .i_last(last),
    .o_ack(ack_a), .o_grant(grant_a), .o_tx_data(txd_a), .o_tx_valid(txv_a),
    .i_tx_ready(ready), .o_busy(busy_a), .o_err_len(err_a)
  );

  nmea_tx_sched #(.N_SRC(N), .MAX_PAYLOAD(4)) u_dut_t (
    .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_data(data), .i_last(last),
    .o_ack(ack_b), .o_grant(grant_b), .o_tx_data(txd_b), .o_tx_valid(txv_b),
    .i_tx_ready(ready), .o_busy(busy_b), .o_err_len(err_b)
  );

  int checks = 0;
  int errors = 0;

  string msg [N];
  int    pos [N];
  int    rep [N];

  byte          rx[$];
  int           gorder[$];
  int           gaps[$];
  int           ack_cnt [N];
  int           acks_no_xfer;
  int           err_pulses;
  int           zero_run;
  logic [N-1:0] prev_grant;
  logic [N-1:0] exp_grant;
  bit           chk_grant;
  bit           chk_busy_lf;
  bit           lf_pending;
  bit           prev_stall;
  logic [7:0]   prev_data;
  bit           rdy_toggle;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (pos[k] < msg[k].len()) begin
        req[k]         = 1'b1;
        data[8*k +: 8] = msg[k][pos[k]];
        last[k]        = (pos[k] == msg[k].len() - 1);
      end else begin
        req[k]         = 1'b0;
        data[8*k +: 8] = 8'h00;
        last[k]        = 1'b0;
      end
    end
  endtask

  task automatic load(input int k, input string s);
    msg[k] = s;
    pos[k] = 0;
    rep[k] = 1;
  endtask

  task automatic clear_sources();
    for (int k = 0; k < N; k++) load(k, "");
    drive();
  endtask

  task automatic start_test();
    rx.delete();
    gorder.delete();
    gaps.delete();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    acks_no_xfer = 0;
    err_pulses   = 0;
    zero_run     = 0;
    prev_grant   = 4'b0000;
    prev_stall   = 1'b0;
    lf_pending   = 1'b0;
    chk_grant    = 1'b0;
    chk_busy_lf  = 1'b0;
  endtask

  // One clock: observe at negedge, advance sources and ready just after posedge.
  task automatic cyc();
    logic [N-1:0] ack_snap;
    @(negedge clk);
    if (lf_pending) begin
      check_eq("busy_after_lf", busy, 1'b0);
      lf_pending = 1'b0;
    end
    if (prev_stall) begin
      check_eq("stall_data", txd, prev_data);
      check_eq("stall_valid", txv, 1'b1);
    end
    prev_stall = txv && !ready;
    prev_data  = txd;
    if (txv && ready) begin
      rx.push_back(txd);
      if (chk_busy_lf && txd == 8'h0A) begin
        check_eq("busy_at_lf", busy, 1'b1);
        lf_pending = 1'b1;
      end
    end
    if (ack != 4'b0000) begin
      check_eq("ack_onehot", $onehot(ack), 1'b1);
      if (!(txv && ready)) acks_no_xfer++;
      for (int k = 0; k < N; k++) if (ack[k]) ack_cnt[k]++;
    end
    if (err) err_pulses++;
    if (chk_grant && busy) check_eq("grant_hold", grant, exp_grant);
    if (grant != 4'b0000 && prev_grant == 4'b0000) begin
      for (int k = 0; k < N; k++) if (grant[k]) gorder.push_back(k);
      gaps.push_back(zero_run);
    end
    if (grant == 4'b0000) zero_run++;
    else zero_run = 0;
    prev_grant = grant;
    ack_snap   = ack;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack_snap[k]) begin
        pos[k]++;
        if (pos[k] == msg[k].len() && rep[k] > 1) begin
          rep[k]--;
          pos[k] = 0;
        end
      end
    end
    ready = rdy_toggle ? ~ready : 1'b1;
    drive();
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    drive();
    do begin
      cyc();
      n++;
    end while ((req != 4'b0000 || busy) && n < maxc);
    check_eq("run_done", {31'd0, (req != 4'b0000 || busy)}, 32'd0);
    cyc();
  endtask

  task automatic check_rx(input string tag, input string exp);
    check_eq({tag, "_len"}, rx.size(), exp.len());
    for (int i = 0; i < exp.len() && i < rx.size(); i++)
      check_eq(tag, rx[i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, grant, 4'b0000);
    check_eq({tag, "_ack"},   ack,   4'b0000);
    check_eq({tag, "_valid"}, txv,   1'b0);
    check_eq({tag, "_data"},  txd,   8'h00);
    check_eq({tag, "_busy"},  busy,  1'b0);
    check_eq({tag, "_err"},   err,   1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b1;
    ready = 1'b1;
  endtask

  initial begin
    int n;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    rst        = 1'b0;
    req        = 4'b0000;
    last       = 4'b0000;
    data       = 32'h0;
    ready      = 1'b1;
    use_t      = 1'b0;
    rdy_toggle = 1'b0;
    clear_sources();
    start_test();
    @(negedge clk);
    check_reset_outputs("rst");
    do_reset();

    // "AB": checksum 0x41^0x42 = 0x03
    start_test();
    chk_busy_lf = 1'b1;
    load(0, "AB");
    run(100);
    check_rx("t1_rx", $sformatf("$AB*03%c%c", 8'h0D, 8'h0A));
    check_eq("t1_acks", ack_cnt[0], 2);
    check_eq("t1_noxfer", acks_no_xfer, 0);

    // "J" = 0x4A exercises the A-F digit mapping
    start_test();
    chk_grant = 1'b1;
    exp_grant = 4'b0100;
    load(2, "J");
    run(100);
    check_rx("t2_rx", $sformatf("$J*4A%c%c", 8'h0D, 8'h0A));
    check_eq("t2_acks", ack_cnt[2], 1);

    // All four request; source 0 requests a second sentence straight away
    do_reset();
    start_test();
    for (int k = 0; k < N; k++) load(k, "A");
    rep[0] = 2;
    run(300);
    check_eq("t3_ngrants", gorder.size(), 5);
    for (int i = 0; i < 5 && i < gorder.size(); i++) check_eq("t3_order", gorder[i], exp_order[i]);
    for (int i = 1; i < 5 && i < gaps.size(); i++) check_eq("t3_gap", gaps[i], 1);
    check_eq("t3_rx_len", rx.size(), 35);

    // "GPGSA" with ready toggling: checksum 0x42
    start_test();
    rdy_toggle = 1'b1;
    load(1, "GPGSA");
    run(200);
    rdy_toggle = 1'b0;
    check_rx("t4_rx", $sformatf("$GPGSA*42%c%c", 8'h0D, 8'h0A));
    check_eq("t4_acks", ack_cnt[1], 5);
    check_eq("t4_noxfer", acks_no_xfer, 0);

    // Truncation at 4 bytes: "ABCD" checksum 0x04, E and F drained
    do_reset();
    use_t = 1'b1;
    start_test();
    load(3, "ABCDEF");
    run(200);
    check_rx("t5_rx", $sformatf("$ABCD*04%c%c", 8'h0D, 8'h0A));
    check_eq("t5_err_pulses", err_pulses, 1);
    check_eq("t5_acks", ack_cnt[3], 6);
    check_eq("t5_drain_acks", acks_no_xfer, 2);
    check_eq("t5_idle", busy, 1'b0);
    use_t = 1'b0;

    // Reset in the middle of "XYZ", then a fresh sentence
    do_reset();
    start_test();
    load(0, "XYZ");
    drive();
    n = 0;
    while (pos[0] < 1 && n < 20) begin
      cyc();
      n++;
    end
    check_eq("t6_in_payload", {31'd0, (pos[0] >= 1)}, 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    clear_sources();
    @(posedge clk);
    #1;
    rst = 1'b1;
    start_test();
    load(0, "AB");
    run(100);
    check_rx("t6_rx", $sformatf("$AB*03%c%c", 8'h0D, 8'h0A));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
